nv_nvdla_cmac_opctl: RTL and testbench

NV_NVDLA_CMAC_OPCTL -- requirements
Module: NV_NVDLA_CMAC_opctl

---
 rtl/nv_nvdla_cmac_opctl_if.sv | 29 ++
 rtl/nv_nvdla_cmac_opctl.sv | 95 +++++++++
 tb/tb_nv_nvdla_cmac_opctl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_cmac_opctl_if.sv
// Register-group control bundle between the CMAC op controller and the
// software-facing register block / datapath.
interface nv_nvdla_cmac_opctl_if;
  logic        reg_op_en_trigger_0;
  logic        reg_op_en_trigger_1;
  logic [15:0] cfg_pkt_num_0;
  logic [15:0] cfg_pkt_num_1;
  logic        dp_pkt_vld;
  logic        reg2dp_op_en;
  logic        reg2dp_consumer;
  logic        dp2reg_done;
  logic [1:0]  op_en_status;
  logic [1:0]  intr_done;
  logic        pkt_err;

  modport master (
    output reg_op_en_trigger_0, reg_op_en_trigger_1,
    output cfg_pkt_num_0, cfg_pkt_num_1, dp_pkt_vld,
    input  reg2dp_op_en, reg2dp_consumer, dp2reg_done,
    input  op_en_status, intr_done, pkt_err
  );

  modport slave (
    input  reg_op_en_trigger_0, reg_op_en_trigger_1,
    input  cfg_pkt_num_0, cfg_pkt_num_1, dp_pkt_vld,
    output reg2dp_op_en, reg2dp_consumer, dp2reg_done,
    output op_en_status, intr_done, pkt_err
  );
endinterface

// File: rtl/nv_nvdla_cmac_opctl.sv
// CMAC layer sequencer: ping-pong register groups, packet counting per layer,
// done/interrupt pulses and the layer enable seen by the core config logic.
//
// state | meaning
// IDLE  | no layer active; waiting for op_en of the consumer group
// RUN   | layer active; counting output packets
// DONE  | single-cycle layer completion; consumer already toggled
module nv_nvdla_cmac_opctl (
  input logic                    nvdla_core_clk,
  input logic                    nvdla_core_rstn,
  nv_nvdla_cmac_opctl_if.slave   ctl
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        consumer;
  logic        consumer_nxt;
  logic [1:0]  op_en;
  logic [1:0]  op_en_nxt;
  logic [1:0]  op_en_clr;
  logic [1:0]  trig;
  logic [15:0] pkt_cnt;
  logic [15:0] pkt_cnt_nxt;
  logic [15:0] cfg_cur;
  logic        op_en_out;
  logic        op_en_out_nxt;
  logic        pkt_err;
  logic        done;

  assign trig    = {ctl.reg_op_en_trigger_1, ctl.reg_op_en_trigger_0};
  assign cfg_cur = consumer ? ctl.cfg_pkt_num_1 : ctl.cfg_pkt_num_0;

  always_comb begin
    state_nxt    = state;
    consumer_nxt = consumer;
    pkt_cnt_nxt  = pkt_cnt;
    op_en_clr    = 2'b00;
    case (state)
      IDLE: if (op_en[consumer]) state_nxt = RUN;
      RUN: begin
        if (ctl.dp_pkt_vld) begin
          if (pkt_cnt == cfg_cur) begin
            state_nxt    = DONE;
            pkt_cnt_nxt  = 16'd0;
            consumer_nxt = ~consumer;
            op_en_clr    = consumer ? 2'b10 : 2'b01;
          end else begin
            pkt_cnt_nxt = pkt_cnt + 16'd1;
          end
        end
      end
      DONE:    state_nxt = op_en[consumer] ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    // a trigger landing on the completing group wins over its clear
    op_en_nxt = trig | (op_en & ~op_en_clr);
    case (state_nxt)
      RUN:     op_en_out_nxt = 1'b1;
      DONE:    op_en_out_nxt = op_en_nxt[consumer_nxt];
      default: op_en_out_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state     <= IDLE;
      consumer  <= 1'b0;
      op_en     <= 2'b00;
      pkt_cnt   <= 16'd0;
      op_en_out <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      consumer  <= consumer_nxt;
      op_en     <= op_en_nxt;
      pkt_cnt   <= pkt_cnt_nxt;
      op_en_out <= op_en_out_nxt;
      if (ctl.dp_pkt_vld && (state != RUN)) pkt_err <= 1'b1;
    end
  end

  // consumer has already toggled in DONE, so the finished group is ~consumer
  assign done                = (state == DONE);
  assign ctl.dp2reg_done     = done;
  assign ctl.intr_done       = {done & ~consumer, done & consumer};
  assign ctl.reg2dp_op_en    = op_en_out;
  assign ctl.reg2dp_consumer = consumer;
  assign ctl.op_en_status    = op_en;
  assign ctl.pkt_err         = pkt_err;

endmodule

// File: tb/tb_nv_nvdla_cmac_opctl.sv
// Directed bench for the CMAC op controller; output vector order is
// {reg2dp_op_en, reg2dp_consumer, dp2reg_done, op_en_status[1:0], intr_done[1:0], pkt_err}.
module tb_nv_nvdla_cmac_opctl;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] obs;

  nv_nvdla_cmac_opctl_if bus ();

  nv_nvdla_cmac_opctl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .ctl             (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.reg2dp_op_en, bus.reg2dp_consumer, bus.dp2reg_done,
            bus.op_en_status, bus.intr_done, bus.pkt_err};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_idle();
    bus.reg_op_en_trigger_0 = 1'b0;
    bus.reg_op_en_trigger_1 = 1'b0;
    bus.dp_pkt_vld          = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic trigger(input logic t0, input logic t1);
    bus.reg_op_en_trigger_0 = t0;
    bus.reg_op_en_trigger_1 = t1;
    tick(1);
    bus.reg_op_en_trigger_0 = 1'b0;
    bus.reg_op_en_trigger_1 = 1'b0;
  endtask

  task automatic send_pkts(input int n);
    bus.dp_pkt_vld = 1'b1;
    tick(n);
    bus.dp_pkt_vld = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.cfg_pkt_num_0 = 16'd0;
    bus.cfg_pkt_num_1 = 16'd0;
    rstn = 1'b0;
    #2;
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_0) begin bad++; $display("FAIL reset_async got=%b exp=%b", obs, 8'b0_0_0_00_00_0); end
    tick(2);
    rstn = 1'b1;
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_0) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, 8'b0_0_0_00_00_0); end
  endtask

  task automatic test_single_layer();
    do_reset();
    bus.cfg_pkt_num_0 = 16'd3;
    bus.cfg_pkt_num_1 = 16'd0;
    trigger(1'b1, 1'b0);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_01_00_0) begin bad++; $display("FAIL single_lat1 got=%b exp=%b", obs, 8'b0_0_0_01_00_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_0) begin bad++; $display("FAIL single_lat2 got=%b exp=%b", obs, 8'b1_0_0_01_00_0); end
    send_pkts(3);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_0) begin bad++; $display("FAIL single_pre got=%b exp=%b", obs, 8'b1_0_0_01_00_0); end
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_1_1_00_01_0) begin bad++; $display("FAIL single_done got=%b exp=%b", obs, 8'b0_1_1_00_01_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b0_1_0_00_00_0) begin bad++; $display("FAIL single_idle got=%b exp=%b", obs, 8'b0_1_0_00_00_0); end
  endtask

  task automatic test_ping_pong();
    do_reset();
    bus.cfg_pkt_num_0 = 16'd1;
    bus.cfg_pkt_num_1 = 16'd2;
    trigger(1'b1, 1'b1);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_11_00_0) begin bad++; $display("FAIL pp_both_set got=%b exp=%b", obs, 8'b0_0_0_11_00_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_11_00_0) begin bad++; $display("FAIL pp_run0 got=%b exp=%b", obs, 8'b1_0_0_11_00_0); end
    send_pkts(2);
    obs = outs(); total++;
    if (obs !== 8'b1_1_1_10_01_0) begin bad++; $display("FAIL pp_done0 got=%b exp=%b", obs, 8'b1_1_1_10_01_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b1_1_0_10_00_0) begin bad++; $display("FAIL pp_run1 got=%b exp=%b", obs, 8'b1_1_0_10_00_0); end
    send_pkts(2);
    obs = outs(); total++;
    if (obs !== 8'b1_1_0_10_00_0) begin bad++; $display("FAIL pp_mid1 got=%b exp=%b", obs, 8'b1_1_0_10_00_0); end
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_0_1_00_10_0) begin bad++; $display("FAIL pp_done1 got=%b exp=%b", obs, 8'b0_0_1_00_10_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_0) begin bad++; $display("FAIL pp_idle got=%b exp=%b", obs, 8'b0_0_0_00_00_0); end
  endtask

  task automatic test_boundary();
    do_reset();
    bus.cfg_pkt_num_0 = 16'd0;
    trigger(1'b1, 1'b0);
    tick(1);
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_1_1_00_01_0) begin bad++; $display("FAIL bnd_zero got=%b exp=%b", obs, 8'b0_1_1_00_01_0); end
    do_reset();
    bus.cfg_pkt_num_0 = 16'hFFFF;
    trigger(1'b1, 1'b0);
    tick(1);
    send_pkts(65535);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_0) begin bad++; $display("FAIL bnd_max_pre got=%b exp=%b", obs, 8'b1_0_0_01_00_0); end
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_1_1_00_01_0) begin bad++; $display("FAIL bnd_max_done got=%b exp=%b", obs, 8'b0_1_1_00_01_0); end
  endtask

  task automatic test_stray();
    do_reset();
    bus.cfg_pkt_num_0 = 16'd3;
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_1) begin bad++; $display("FAIL stray_err got=%b exp=%b", obs, 8'b0_0_0_00_00_1); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_1) begin bad++; $display("FAIL stray_sticky got=%b exp=%b", obs, 8'b0_0_0_00_00_1); end
    trigger(1'b1, 1'b0);
    tick(1);
    send_pkts(3);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_1) begin bad++; $display("FAIL stray_pre got=%b exp=%b", obs, 8'b1_0_0_01_00_1); end
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_1_1_00_01_1) begin bad++; $display("FAIL stray_done got=%b exp=%b", obs, 8'b0_1_1_00_01_1); end
  endtask

  task automatic test_collision();
    do_reset();
    bus.cfg_pkt_num_0 = 16'd1;
    bus.cfg_pkt_num_1 = 16'd0;
    trigger(1'b1, 1'b1);
    tick(1);
    send_pkts(1);
    bus.dp_pkt_vld          = 1'b1;
    bus.reg_op_en_trigger_0 = 1'b1;
    tick(1);
    bus.dp_pkt_vld          = 1'b0;
    bus.reg_op_en_trigger_0 = 1'b0;
    obs = outs(); total++;
    if (obs !== 8'b1_1_1_11_01_0) begin bad++; $display("FAIL coll_done0 got=%b exp=%b", obs, 8'b1_1_1_11_01_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b1_1_0_11_00_0) begin bad++; $display("FAIL coll_run1 got=%b exp=%b", obs, 8'b1_1_0_11_00_0); end
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b1_0_1_01_10_0) begin bad++; $display("FAIL coll_done1 got=%b exp=%b", obs, 8'b1_0_1_01_10_0); end
    tick(1);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_0) begin bad++; $display("FAIL coll_rerun0 got=%b exp=%b", obs, 8'b1_0_0_01_00_0); end
    send_pkts(2);
    obs = outs(); total++;
    if (obs !== 8'b0_1_1_00_01_0) begin bad++; $display("FAIL coll_done0b got=%b exp=%b", obs, 8'b0_1_1_00_01_0); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.cfg_pkt_num_0 = 16'd3;
    trigger(1'b1, 1'b0);
    tick(1);
    send_pkts(2);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_0) begin bad++; $display("FAIL mid_running got=%b exp=%b", obs, 8'b1_0_0_01_00_0); end
    #2;
    rstn = 1'b0;
    #1;
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_0) begin bad++; $display("FAIL mid_rst_async got=%b exp=%b", obs, 8'b0_0_0_00_00_0); end
    tick(2);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_00_00_0) begin bad++; $display("FAIL mid_rst_hold got=%b exp=%b", obs, 8'b0_0_0_00_00_0); end
    rstn = 1'b1;
    trigger(1'b1, 1'b0);
    obs = outs(); total++;
    if (obs !== 8'b0_0_0_01_00_0) begin bad++; $display("FAIL mid_retrig got=%b exp=%b", obs, 8'b0_0_0_01_00_0); end
    tick(1);
    send_pkts(3);
    obs = outs(); total++;
    if (obs !== 8'b1_0_0_01_00_0) begin bad++; $display("FAIL mid_pre got=%b exp=%b", obs, 8'b1_0_0_01_00_0); end
    send_pkts(1);
    obs = outs(); total++;
    if (obs !== 8'b0_1_1_00_01_0) begin bad++; $display("FAIL mid_done got=%b exp=%b", obs, 8'b0_1_1_00_01_0); end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_ping_pong();
    test_boundary();
    test_stray();
    test_collision();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
